pe_array_ctrl: RTL and testbench
================================

// Module: pe_array_ctrl
// PURPOSE
//  Sequencer for the PE array. Programs the operating mode and loads filters by broadcasting
//  filter packets, then streams ifmap packets on the shared PE packet bus. Runs NUM_ROUNDS
//  convolution rounds, driving conv_continue and collecting conv_done, full and error from every PE.
//  Sits between the global buffer read ports and the PE array broadcast bus.
// PARAMETERS
//  NUM_PE   12  number of PEs on the broadcast bus
//  DATA_W   32  packet payload width (4 x 8-bit ifmap/weight elements)
//  IDX_W    6   packet_idx width ([4:3] filter slot, [2:0] row for filter packets)
//  CNT_W    10  width of the packet and round counters
// PORTS
//  clk            in   1        clock
//  rst            in   1        async reset, active-high
//  start          in   1        level; sampled in IDLE only
//  abort          in   1        return to IDLE from any state
//  cfg_mode       in   2        OP_MODE to program (MODE1..MODE4 = 0..3)
//  cfg_flt_pkts   in   CNT_W    filter packets per job (>=1)
//  cfg_if_pkts    in   CNT_W    ifmap packets per round (>=1)
//  cfg_rounds     in   CNT_W    rounds per job (>=1)
//  flt_valid/flt_ready  in/out 1  filter source handshake
//  flt_idx, flt_data    in  IDX_W/DATA_W  filter packet fields
//  if_valid/if_ready    in/out 1  ifmap source handshake
//  if_idx, if_data      in  IDX_W/DATA_W  ifmap packet fields
//  pe_full        in   NUM_PE   per-PE ifmap scratchpad full
//  pe_conv_done   in   NUM_PE   per-PE convolution done
//  pe_error       in   NUM_PE   per-PE overflow error
//  mode           out  2        mode to PEs
//  change_mode    out  1        1-cycle pulse that latches mode into the PEs
//  op_stage       out  2        IDLE=0, LOAD_FILTER=1, CONV=2
//  pe_pkt_valid   out  1        broadcast packet valid (registered)
//  pe_pkt_idx     out  IDX_W    broadcast packet index
//  pe_pkt_data    out  DATA_W   broadcast payload
//  conv_continue  out  1        1-cycle pulse: PEs start a round
//  busy/done/err  out  1        status: busy level, done 1-cycle pulse, err sticky
//  stall_cycles   out  16       perf counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, all counters 0.
//  FSM: IDLE -> CFG -> LOAD_FLT -> CONV -> WAIT_DONE -> (CONV | FINISH) -> IDLE; ERROR is absorbing.
//  IDLE: when start=1, latch cfg_* and go to CFG. busy=1 from the next cycle until FINISH.
//  CFG: lasts 1 cycle. change_mode=1 and mode=latched cfg_mode. Then go to LOAD_FLT.
//  LOAD_FLT: op_stage=1. flt_ready = (flt_cnt < cfg_flt_pkts).
//   - Each flt handshake registers onto pe_pkt_* in the next cycle, for exactly 1 cycle.
//   - After the last handshake, go to CONV.
//  CONV: op_stage=2.
//   - On the entry cycle, conv_continue=1 and if_ready=0.
//   - After that, if_ready = ~|pe_full && if_cnt < cfg_if_pkts.
//   - Each beat is broadcast with 1-cycle latency, the same way as filter packets.
//   - After the last beat, go to WAIT_DONE.
//  WAIT_DONE: op_stage=2, no issue.
//   - When &pe_conv_done: round_cnt++ and if_cnt=0.
//   - If round_cnt+1 < cfg_rounds, go to CONV (new conv_continue); else go to FINISH.
//  FINISH: done=1 for 1 cycle, then IDLE.
//  Error: |pe_error in any state except IDLE goes to ERROR.
//   - err=1 (sticky) and ready outputs=0.
//   - pe_pkt_valid=0 from the next cycle.
//   - ERROR exits only on abort or rst.
//  abort: takes priority over every event.
//   - Next cycle: state=IDLE, pe_pkt_valid=0, err cleared, counters cleared.
//   - No done pulse.
//  Priority within a cycle: abort > pe_error > normal transitions.
//  start held high at FINISH: accepted only after IDLE is reached (1 idle cycle minimum).
//  flt_ready and if_ready depend only on registered state and pe_full, never on *_valid.
//  Counters saturate at cfg values; they never wrap.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined:
//   - stall_cycles counts cycles in CONV after the entry cycle with if_valid=1, if_cnt<cfg_if_pkts, |pe_full=1.
//   - Saturates at 16'hFFFF; cleared on start acceptance and on abort.
//  Not defined: stall_cycles tied to 16'h0000 and no counter logic is built.
// TESTING
//  1 Reset: assert rst mid-job -> all outputs 0 immediately (async); after release state=IDLE.
//  2 Config: cfg_mode=2, flt=8, if=3, rounds=1, sources always valid ->
//    - change_mode pulse with mode=2, then 8 consecutive filter packets, then conv_continue;
//    - 3 ifmap packets, then done 1 cycle after &pe_conv_done.
//  3 Backpressure: pe_full[5]=1 for 4 cycles during CONV -> if_ready=0 for those cycles;
//    no packet lost or duplicated; stall_cycles=4 with CTRL_PERF_CNT_EN, else 0.
//  4 Multi-round: rounds=3 -> exactly 3 conv_continue pulses and 3x cfg_if_pkts ifmap beats, then one done pulse.
//  5 Error: pe_error[0]=1 in CONV -> err=1, ready outputs low, no further packets; abort -> IDLE, err=0.
//  6 Abort: abort in LOAD_FLT with flt_valid=1 -> no handshake that cycle, pe_pkt_valid=0 next cycle, no done.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// PE array sequencer: programs the PE mode, broadcasts filter packets, then streams ifmap rounds.
// Build option CTRL_PERF_CNT_EN adds the stall_cycles performance counter.
module pe_array_ctrl #(
    parameter int unsigned NUM_PE = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_flt_pkts,
    input  logic [CNT_W-1:0]  cfg_if_pkts,
    input  logic [CNT_W-1:0]  cfg_rounds,
    input  logic              flt_valid,
    output logic              flt_ready,
    input  logic [IDX_W-1:0]  flt_idx,
    input  logic [DATA_W-1:0] flt_data,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [IDX_W-1:0]  if_idx,
    input  logic [DATA_W-1:0] if_data,
    input  logic [NUM_PE-1:0] pe_full,
    input  logic [NUM_PE-1:0] pe_conv_done,
    input  logic [NUM_PE-1:0] pe_error,
    output logic [1:0]        mode,
    output logic              change_mode,
    output logic [1:0]        op_stage,
    output logic              pe_pkt_valid,
    output logic [IDX_W-1:0]  pe_pkt_idx,
    output logic [DATA_W-1:0] pe_pkt_data,
    output logic              conv_continue,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD_FLT, S_CONV, S_WAIT_DONE, S_FINISH, S_ERROR
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cfg_flt_q, cfg_if_q, cfg_rounds_q;
    logic [CNT_W-1:0]   flt_cnt_q, if_cnt_q, round_cnt_q;
    logic [CNT_W-1:0]   flt_cnt_d, if_cnt_d, round_cnt_d;
    logic [1:0]         mode_q, op_stage_q;
    logic               change_mode_q, conv_continue_q, busy_q, done_q, err_q;
    logic               pkt_valid_q;
    logic [IDX_W-1:0]   pkt_idx_q;
    logic [DATA_W-1:0]  pkt_data_q;
    logic               any_full, any_err, all_done, flt_hs, if_hs;

    assign any_full  = |pe_full;
    assign any_err   = |pe_error;
    assign all_done  = &pe_conv_done;
    assign flt_cnt_d   = flt_cnt_q + CNT_W'(1);
    assign if_cnt_d    = if_cnt_q + CNT_W'(1);
    assign round_cnt_d = round_cnt_q + CNT_W'(1);

    // Ready is dropped in a cycle that aborts or errors so no beat is accepted and then discarded.
    assign flt_ready = (state_q == S_LOAD_FLT) && (flt_cnt_q < cfg_flt_q) && !abort && !any_err;
    assign if_ready  = (state_q == S_CONV) && !conv_continue_q && !any_full &&
                       (if_cnt_q < cfg_if_q) && !abort && !any_err;
    assign flt_hs    = flt_valid && flt_ready;
    assign if_hs     = if_valid && if_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cfg_flt_q       <= '0;
            cfg_if_q        <= '0;
            cfg_rounds_q    <= '0;
            flt_cnt_q       <= '0;
            if_cnt_q        <= '0;
            round_cnt_q     <= '0;
            mode_q          <= '0;
            op_stage_q      <= '0;
            change_mode_q   <= 1'b0;
            conv_continue_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            pkt_valid_q     <= 1'b0;
            pkt_idx_q       <= '0;
            pkt_data_q      <= '0;
        end else begin
            change_mode_q   <= 1'b0;
            conv_continue_q <= 1'b0;
            done_q          <= 1'b0;
            pkt_valid_q     <= 1'b0;
            if (abort) begin
                state_q     <= S_IDLE;
                flt_cnt_q   <= '0;
                if_cnt_q    <= '0;
                round_cnt_q <= '0;
                op_stage_q  <= '0;
                busy_q      <= 1'b0;
                err_q       <= 1'b0;
            end else if (any_err && state_q != S_IDLE) begin
                state_q    <= S_ERROR;
                op_stage_q <= '0;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        state_q       <= S_CFG;
                        cfg_flt_q     <= cfg_flt_pkts;
                        cfg_if_q      <= cfg_if_pkts;
                        cfg_rounds_q  <= cfg_rounds;
                        flt_cnt_q     <= '0;
                        if_cnt_q      <= '0;
                        round_cnt_q   <= '0;
                        mode_q        <= cfg_mode;
                        change_mode_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                    S_CFG: begin
                        state_q    <= S_LOAD_FLT;
                        op_stage_q <= 2'd1;
                    end
                    S_LOAD_FLT: if (flt_hs) begin
                        pkt_valid_q <= 1'b1;
                        pkt_idx_q   <= flt_idx;
                        pkt_data_q  <= flt_data;
                        flt_cnt_q   <= flt_cnt_d;
                        if (flt_cnt_d == cfg_flt_q) begin
                            state_q         <= S_CONV;
                            op_stage_q      <= 2'd2;
                            conv_continue_q <= 1'b1;
                        end
                    end
                    S_CONV: if (if_hs) begin
                        pkt_valid_q <= 1'b1;
                        pkt_idx_q   <= if_idx;
                        pkt_data_q  <= if_data;
                        if_cnt_q    <= if_cnt_d;
                        if (if_cnt_d == cfg_if_q) state_q <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: if (all_done) begin
                        if_cnt_q <= '0;
                        if (round_cnt_q < cfg_rounds_q) round_cnt_q <= round_cnt_d;
                        if (round_cnt_d < cfg_rounds_q) begin
                            state_q         <= S_CONV;
                            conv_continue_q <= 1'b1;
                        end else begin
                            state_q    <= S_FINISH;
                            op_stage_q <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                    S_FINISH: state_q <= S_IDLE;
                    S_ERROR:  state_q <= S_ERROR;
                    default:  state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] stall_q;

    // Counts cycles where the source has data but a full PE scratchpad holds it back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (abort || (state_q == S_IDLE && start)) begin
            stall_q <= '0;
        end else if (state_q == S_CONV && !conv_continue_q && if_valid &&
                     (if_cnt_q < cfg_if_q) && any_full && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

    assign mode          = mode_q;
    assign change_mode   = change_mode_q;
    assign op_stage      = op_stage_q;
    assign pe_pkt_valid  = pkt_valid_q;
    assign pe_pkt_idx    = pkt_idx_q;
    assign pe_pkt_data   = pkt_data_q;
    assign conv_continue = conv_continue_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed bench for pe_array_ctrl: sources advance only on handshakes, a monitor checks every
// broadcast packet in order, and scenarios check the control pulses at exact cycles.
module tb_pe_array_ctrl;

    logic        clk, rst, start, abort;
    logic [1:0]  cfg_mode;
    logic [9:0]  cfg_flt_pkts, cfg_if_pkts, cfg_rounds;
    logic        flt_valid, flt_ready, if_valid, if_ready;
    logic [5:0]  flt_idx, if_idx, pe_pkt_idx;
    logic [31:0] flt_data, if_data, pe_pkt_data;
    logic [11:0] pe_full, pe_conv_done, pe_error;
    logic [1:0]  mode, op_stage;
    logic        change_mode, pe_pkt_valid, conv_continue, busy, done, err;
    logic [15:0] stall_cycles;

    int n_cmp = 0, n_err = 0;
    int flt_sent = 0, if_sent = 0, exp_flt = 0, exp_if = 0;
    int n_flt = 0, n_if = 0, n_cc = 0, n_cm = 0, n_done = 0;
    logic [15:0] exp_stall;

    pe_array_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_mode(cfg_mode),
        .cfg_flt_pkts(cfg_flt_pkts), .cfg_if_pkts(cfg_if_pkts), .cfg_rounds(cfg_rounds),
        .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_idx(flt_idx), .flt_data(flt_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_idx(if_idx), .if_data(if_data),
        .pe_full(pe_full), .pe_conv_done(pe_conv_done), .pe_error(pe_error),
        .mode(mode), .change_mode(change_mode), .op_stage(op_stage),
        .pe_pkt_valid(pe_pkt_valid), .pe_pkt_idx(pe_pkt_idx), .pe_pkt_data(pe_pkt_data),
        .conv_continue(conv_continue), .busy(busy), .done(done), .err(err),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packet sources: payload encodes the sequence number, advanced only on handshake.
    assign flt_idx  = 6'(flt_sent);
    assign flt_data = 32'hF000_0000 | 32'(flt_sent);
    assign if_idx   = 6'(if_sent);
    assign if_data  = 32'hA000_0000 | 32'(if_sent);

    always @(posedge clk) begin
        if (flt_valid && flt_ready) flt_sent <= flt_sent + 1;
        if (if_valid && if_ready) if_sent <= if_sent + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (change_mode) n_cm++;
            if (conv_continue) n_cc++;
            if (done) n_done++;
            if (pe_pkt_valid) begin
                if (pe_pkt_data[31:28] == 4'hF) begin
                    check("pkt_flt_data", pe_pkt_data, 32'hF000_0000 | 32'(exp_flt));
                    check("pkt_flt_idx", 32'(pe_pkt_idx), 32'(exp_flt & 63));
                    exp_flt++;
                    n_flt++;
                end else begin
                    check("pkt_if_data", pe_pkt_data, 32'hA000_0000 | 32'(exp_if));
                    check("pkt_if_idx", 32'(pe_pkt_idx), 32'(exp_if & 63));
                    exp_if++;
                    n_if++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        n_flt = 0; n_if = 0; n_cc = 0; n_cm = 0; n_done = 0;
    endtask

    task automatic start_job(input logic [1:0] m, input int f, input int i, input int r);
        clr_cnt();
        cfg_mode = m; cfg_flt_pkts = 10'(f); cfg_if_pkts = 10'(i); cfg_rounds = 10'(r);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_cc(input string tag);
        for (int k = 0; k < 60 && conv_continue !== 1'b1; k++) step();
        check(tag, 32'(conv_continue), 1);
    endtask

    task automatic wait_if(input string tag, input int target);
        for (int k = 0; k < 100 && n_if < target; k++) step();
        check(tag, 32'(n_if), 32'(target));
    endtask

    task automatic finish_round();
        pe_conv_done = '1;
        step();
        pe_conv_done = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_mode = '0;
        cfg_flt_pkts = '0; cfg_if_pkts = '0; cfg_rounds = '0;
        flt_valid = 1'b1; if_valid = 1'b1;
        pe_full = '0; pe_conv_done = '0; pe_error = '0;
`ifdef CTRL_PERF_CNT_EN
        exp_stall = 16'd4;
`else
        exp_stall = 16'd0;
`endif
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_op_stage", 32'(op_stage), 0);
        check("rst_pkt_valid", 32'(pe_pkt_valid), 0);
        check("rst_flt_ready", 32'(flt_ready), 0);
        check("rst_if_ready", 32'(if_ready), 0);
        check("rst_err_done", 32'({err, done, conv_continue, change_mode}), 0);
        @(posedge clk); #1 rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 0);

        // Single round: mode 2, 8 filter packets, 3 ifmap packets
        start_job(2'd2, 8, 3, 1);
        check("cfg_change_mode", 32'(change_mode), 1);
        check("cfg_mode", 32'(mode), 2);
        check("cfg_busy", 32'(busy), 1);
        step();
        check("ld_op_stage", 32'(op_stage), 1);
        check("ld_flt_ready", 32'(flt_ready), 1);
        check("ld_change_mode_low", 32'(change_mode), 0);
        repeat (8) step();
        check("conv_entry_cc", 32'(conv_continue), 1);
        check("conv_entry_if_ready", 32'(if_ready), 0);
        check("conv_op_stage", 32'(op_stage), 2);
        check("last_flt_pkt", pe_pkt_data, 32'hF000_0007);
        step();
        check("conv_if_ready", 32'(if_ready), 1);
        check("conv_cc_low", 32'(conv_continue), 0);
        repeat (3) step();
        check("wait_if_ready", 32'(if_ready), 0);
        check("wait_op_stage", 32'(op_stage), 2);
        finish_round();
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        // Start held from FINISH is only taken once IDLE is reached
        cfg_mode = 2'd1; cfg_flt_pkts = 10'd1; cfg_if_pkts = 10'd6; cfg_rounds = 10'd1;
        start = 1'b1;
        step();
        check("no_start_in_finish", 32'(change_mode), 0);
        check("done_low", 32'(done), 0);
        check("s2_flt_cnt", 32'(n_flt), 8);
        check("s2_if_cnt", 32'(n_if), 3);
        check("s2_cc_cnt", 32'(n_cc), 1);
        check("s2_done_cnt", 32'(n_done), 1);
        check("s2_cm_cnt", 32'(n_cm), 1);
        clr_cnt();
        step();
        start = 1'b0;
        check("start_after_idle", 32'(change_mode), 1);

        // Backpressure: pe_full[5] for 4 cycles during CONV
        wait_cc("bp_cc");
        check("bp_stall_cleared", 32'(stall_cycles), 0);
        step();
        check("bp_ready_pre", 32'(if_ready), 1);
        pe_full = 12'h020;
        #1;
        check("bp_ready_0", 32'(if_ready), 0);
        for (int k = 1; k < 4; k++) begin
            step();
            check("bp_ready_held", 32'(if_ready), 0);
        end
        step();
        check("bp_stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        pe_full = '0;
        #1;
        check("bp_ready_release", 32'(if_ready), 1);
        wait_if("bp_if_beats", 6);
        finish_round();
        check("bp_done", 32'(done), 1);
        step();
        check("bp_if_total", 32'(n_if), 6);

        // Three rounds of 2 ifmap packets
        start_job(2'd1, 2, 2, 3);
        wait_cc("mr_cc1");
        wait_if("mr_if1", 2);
        finish_round();
        wait_cc("mr_cc2");
        wait_if("mr_if2", 4);
        finish_round();
        wait_cc("mr_cc3");
        wait_if("mr_if3", 6);
        finish_round();
        check("mr_done", 32'(done), 1);
        repeat (2) step();
        check("mr_cc_cnt", 32'(n_cc), 3);
        check("mr_if_cnt", 32'(n_if), 6);
        check("mr_done_cnt", 32'(n_done), 1);

        // PE error during CONV
        start_job(2'd0, 1, 4, 1);
        wait_cc("er_cc");
        repeat (2) step();
        pe_error = 12'h001;
        #1;
        check("er_ready_gate", 32'(if_ready), 0);
        step();
        pe_error = '0;
        check("er_err", 32'(err), 1);
        check("er_pkt_valid", 32'(pe_pkt_valid), 0);
        check("er_busy", 32'(busy), 0);
        check("er_if_pkts", 32'(n_if), 1);
        repeat (4) step();
        check("er_sticky", 32'(err), 1);
        check("er_ready_low", 32'({flt_ready, if_ready}), 0);
        check("er_no_more_pkts", 32'(n_if), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("er_abort_clear", 32'(err), 0);
        check("er_abort_stage", 32'(op_stage), 0);
        check("er_no_done", 32'(n_done), 0);

        // Abort during LOAD_FLT
        start_job(2'd2, 8, 1, 1);
        step();
        check("ab_op_stage", 32'(op_stage), 1);
        repeat (2) step();
        abort = 1'b1;
        #1;
        check("ab_no_hs", 32'(flt_ready), 0);
        step();
        abort = 1'b0;
        check("ab_pkt_valid", 32'(pe_pkt_valid), 0);
        check("ab_idle", 32'({busy, op_stage}), 0);
        repeat (3) step();
        check("ab_flt_cnt", 32'(n_flt), 2);
        check("ab_no_done", 32'(n_done), 0);

        // Asynchronous reset in the middle of a job
        start_job(2'd3, 2, 2, 2);
        wait_cc("rs_cc");
        wait_if("rs_if", 2);
        #3 rst = 1'b1;
        #1;
        check("rs_async_mode", 32'(mode), 0);
        check("rs_async_busy", 32'(busy), 0);
        check("rs_async_stage", 32'(op_stage), 0);
        check("rs_async_ready", 32'({flt_ready, if_ready, pe_pkt_valid}), 0);
        @(posedge clk); #1 rst = 1'b0;
        step();
        check("rs_idle", 32'({busy, op_stage}), 0);
        start_job(2'd1, 1, 1, 1);
        check("rs_restart_cm", 32'(change_mode), 1);
        wait_cc("rs_restart_cc");
        wait_if("rs_restart_if", 1);
        finish_round();
        check("rs_restart_done", 32'(done), 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
